// File: rtl/regwb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Used by regwb_fifo and regfile_wb_arbiter (optional macro REGWB_STARVE_GUARD_EN).
package regwb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
        logic                  stale;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_REQ0,
        GNT_FIFO
    } grant_t;

endpackage

// File: rtl/regwb_fifo.sv
// Synchronous FIFO of writeback entries for the long-latency requester,
// with a match-and-mark port that flags buffered writes as stale.
module regwb_fifo
    import regwb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  wb_entry_t               push_entry,
    input  logic                    pop,
    input  logic                    mark_en,
    input  logic [REG_ADDR_W-1:0]   mark_rd,
    output wb_entry_t               head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PTR_W'(i)].stale <= 1'b0;
            end
        end else begin
            // Marking empty slots is harmless: a push rewrites the stale bit.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (mark_en && mem[PTR_W'(i)].rd == mark_rd) begin
                    mem[PTR_W'(i)].stale <= 1'b1;
                end
            end
            if (push) begin
                mem[wr_ptr] <= '{rd:    push_entry.rd,
                                 data:  push_entry.data,
                                 stale: push_entry.stale | (mark_en && push_entry.rd == mark_rd)};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file write port between the pipeline (priority) and a
// buffered long-latency requester. REGWB_STARVE_GUARD_EN adds a starvation guard.
module regfile_wb_arbiter
    import regwb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                         Clk,
    input  logic                         rst_n,
    input  logic                         req0_valid,
    input  logic [4:0]                   req0_rd,
    input  logic [31:0]                  req0_data,
    output logic                         req0_ready,
    input  logic                         req1_valid,
    input  logic [4:0]                   req1_rd,
    input  logic [31:0]                  req1_data,
    output logic                         req1_ready,
    output logic                         WEN,
    output logic [4:0]                   RW,
    output logic [31:0]                  busW,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("regfile_wb_arbiter: FIFO_DEPTH must be a power of 2 >= 2, STARVE_LIMIT >= 1");
    end

    wb_entry_t head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      push;
    logic      pop;
    logic      forced;
    grant_t    grant;

`ifdef REGWB_STARVE_GUARD_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_cnt;

    assign forced = (starve_cnt == STARVE_W'(STARVE_LIMIT));

    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (pop || fifo_empty) begin
            starve_cnt <= '0;
        end else if (grant == GNT_REQ0) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign forced = 1'b0;
`endif

    assign req0_ready = !forced;
    assign req1_ready = !fifo_full;
    assign push       = req1_valid && req1_ready;
    assign pop        = (grant == GNT_FIFO);

    always_comb begin
        grant = GNT_IDLE;
        if (forced && !fifo_empty) begin
            grant = GNT_FIFO;
        end else if (req0_valid && req0_ready) begin
            grant = GNT_REQ0;
        end else if (!fifo_empty) begin
            grant = GNT_FIFO;
        end
    end

    regwb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (Clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry ('{rd: req1_rd, data: req1_data, stale: 1'b0}),
        .pop        (pop),
        .mark_en    (grant == GNT_REQ0 && req0_rd != ZERO_REG),
        .mark_rd    (req0_rd),
        .head       (head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // RW/busW follow every grant (even rd==0 or stale); only WEN is suppressed.
    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            WEN  <= 1'b0;
            RW   <= '0;
            busW <= '0;
        end else begin
            case (grant)
                GNT_REQ0: begin
                    WEN  <= (req0_rd != ZERO_REG);
                    RW   <= req0_rd;
                    busW <= req0_data;
                end
                GNT_FIFO: begin
                    WEN  <= (head.rd != ZERO_REG) && !head.stale;
                    RW   <= head.rd;
                    busW <= head.data;
                end
                default: begin
                    WEN <= 1'b0;
                end
            endcase
        end
    end

endmodule
